master_port: RTL and testbench

MASTER_PORT -- requirements
Module: master_port

---
 rtl/master_port.sv | 182 ++++++++++++++++++
 tb/tb_master_port.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/master_port.sv
// Serial bus master: one 16-bit address phase, then an 8-bit write or read phase,
// framed by ack handshakes. Optional ack timeout via MASTER_PORT_ACK_TIMEOUT_EN.
module master_port (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        M_EXECUTE,
  input  logic        M_RW,
  input  logic [15:0] M_ADDR,
  input  logic [7:0]  M_DIN,
  output logic [7:0]  M_DOUT,
  output logic        M_DVALID,
  output logic        M_DONE,
  output logic        M_BUSY,
  output logic        M_ERR,
  output logic        AD_SEL,
  output logic        B_RW,
  output logic        B_BUS_OUT,
  input  logic        B_BUS_IN,
  input  logic        B_ACK,
  input  logic        B_SBSY,
  output logic [2:0]  DBG_STATE
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDRESS   = 3'd1,
    S_WAIT_ACKA = 3'd2,
    S_WRITE     = 3'd3,
    S_WAIT_ACKW = 3'd4,
    S_READ      = 3'd5,
    S_DONE      = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic        rw_q, rw_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  dout_q, dout_d;

`ifdef MASTER_PORT_ACK_TIMEOUT_EN
  logic [4:0]  tmo_q, tmo_d;
  logic        err_q, err_d;
`endif

  // B_SBSY is informational only.
  logic unused_sbsy;
  assign unused_sbsy = B_SBSY;

  // Handshake: a request is a single cycle with M_EXECUTE=1 while the block is idle
  // (M_BUSY=0); it is accepted on that edge and M_BUSY rises the next cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    data_d  = data_q;
    shift_d = shift_q;
    dout_d  = dout_q;
`ifdef MASTER_PORT_ACK_TIMEOUT_EN
    tmo_d   = 5'd0;
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (M_EXECUTE) begin
          rw_d    = M_RW;
          addr_d  = M_ADDR;
          data_d  = M_DIN;
          shift_d = 8'h00;
          cnt_d   = 4'd0;
          armed_d = 1'b0;
          state_d = S_ADDRESS;
        end
      end
      S_ADDRESS: begin
        if (cnt_q == 4'd15) begin
          cnt_d   = 4'd0;
          state_d = S_WAIT_ACKA;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WAIT_ACKA, S_WAIT_ACKW: begin
        // Ack is a level that must rise and then fall before the phase advances.
        if (armed_q) begin
          if (!B_ACK) begin
            armed_d = 1'b0;
            cnt_d   = 4'd0;
            if (state_q == S_WAIT_ACKW) state_d = S_DONE;
            else                        state_d = rw_q ? S_WRITE : S_READ;
          end
        end else if (B_ACK) begin
          armed_d = 1'b1;
        end
`ifdef MASTER_PORT_ACK_TIMEOUT_EN
        else if (tmo_q == 5'd31) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 5'd1;
        end
`endif
      end
      S_WRITE: begin
        if (cnt_q == 4'd7) begin
          cnt_d   = 4'd0;
          state_d = S_WAIT_ACKW;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_READ: begin
        shift_d[cnt_q[2:0]] = B_BUS_IN;
        if (cnt_q == 4'd7) begin
          cnt_d   = 4'd0;
          dout_d  = shift_d;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      armed_q <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= 16'h0000;
      data_q  <= 8'h00;
      shift_q <= 8'h00;
      dout_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
    end
  end

`ifdef MASTER_PORT_ACK_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      tmo_q <= 5'd0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign M_ERR = err_q;
`else
  assign M_ERR = 1'b0;
`endif

  assign AD_SEL    = (state_q == S_ADDRESS);
  assign B_BUS_OUT = (state_q == S_ADDRESS) ? addr_q[cnt_q] :
                     (state_q == S_WRITE)   ? data_q[cnt_q[2:0]] : 1'b0;
  assign M_BUSY    = (state_q != S_IDLE);
  assign M_DONE    = (state_q == S_DONE);
  assign M_DVALID  = (state_q == S_DONE) && !rw_q;
  assign M_DOUT    = dout_q;
  assign B_RW      = rw_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_master_port.sv
// Bench for master_port: directed and randomized transfers walked cycle by cycle
// against the bus protocol timeline, with a scoreboard of expected serial words.
module tb_master_port;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        M_EXECUTE;
  logic        M_RW;
  logic [15:0] M_ADDR;
  logic [7:0]  M_DIN;
  logic [7:0]  M_DOUT;
  logic        M_DVALID;
  logic        M_DONE;
  logic        M_BUSY;
  logic        M_ERR;
  logic        AD_SEL;
  logic        B_RW;
  logic        B_BUS_OUT;
  logic        B_BUS_IN;
  logic        B_ACK;
  logic        B_SBSY;
  logic [2:0]  DBG_STATE;

  master_port dut (
    .CLK(CLK), .RSTN(RSTN), .M_EXECUTE(M_EXECUTE), .M_RW(M_RW), .M_ADDR(M_ADDR),
    .M_DIN(M_DIN), .M_DOUT(M_DOUT), .M_DVALID(M_DVALID), .M_DONE(M_DONE),
    .M_BUSY(M_BUSY), .M_ERR(M_ERR), .AD_SEL(AD_SEL), .B_RW(B_RW),
    .B_BUS_OUT(B_BUS_OUT), .B_BUS_IN(B_BUS_IN), .B_ACK(B_ACK), .B_SBSY(B_SBSY),
    .DBG_STATE(DBG_STATE)
  );

  // ---- clock / reset ----
  always #5 CLK = ~CLK;

  // ---- scoreboard state ----
  int          n_tests  = 0;
  int          n_failed = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  last_rd;
  logic        cur_rw;
  bit          cur_hold;
  bit          busy_ok;
  bit          quiet_ok;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---- driver tasks ----
  task automatic junk();
    M_EXECUTE = cur_hold ? 1'b1 : 1'($urandom_range(0, 1));
    M_RW      = 1'($urandom);
    M_ADDR    = 16'($urandom);
    M_DIN     = 8'($urandom);
    B_BUS_IN  = 1'($urandom);
    B_SBSY    = 1'($urandom);
  endtask

  task automatic mid_check(input logic ad_exp, input bit bus_zero);
    if (M_BUSY !== 1'b1 || B_RW !== cur_rw || M_DONE !== 1'b0 || M_DVALID !== 1'b0 ||
        M_ERR !== 1'b0 || M_DOUT !== last_rd || AD_SEL !== ad_exp) busy_ok = 0;
    if (bus_zero && B_BUS_OUT !== 1'b0) quiet_ok = 0;
  endtask

  task automatic ack_phase(input int d, input int len);
    for (int j = 0; j < d + len + 1; j++) begin
      mid_check(1'b0, 1'b1);
      junk();
      B_ACK = (j >= d) && (j < d + len);
      @(negedge CLK);
    end
    B_ACK = 1'b0;
  endtask

  task automatic do_abort();
    RSTN = 1'b0;
    #1;
    chk("rst_async_outs", 32'({AD_SEL, B_BUS_OUT, M_BUSY, M_DONE, M_DVALID, M_ERR}), 32'd0);
    chk("rst_async_dout", 32'(M_DOUT), 32'd0);
    last_rd  = 8'h00;
    cur_hold = 0;
    M_EXECUTE = 1'b0;
    @(negedge CLK);
    chk("rst_next_outs", 32'({AD_SEL, B_BUS_OUT, M_BUSY, M_DONE, M_DVALID, M_ERR}), 32'd0);
    RSTN = 1'b1;
    @(negedge CLK);
    chk("rst_release_idle", 32'({M_BUSY, M_DONE, M_DVALID, M_ERR, AD_SEL}), 32'd0);
  endtask

  // Walks one transfer along the expected protocol timeline, starting on an idle negedge.
  task automatic xfer(input logic rw, input logic [15:0] addr, input logic [7:0] din,
                      input logic [7:0] rdata, input int da, input int dw, input int alen,
                      input bit hold, input int abort_bit);
    logic [15:0] a_obs;
    logic [7:0]  d_obs;
    a_obs = '0;
    d_obs = '0;
    exp_q.push_back(addr);
    if (rw) exp_q.push_back({8'h00, din});
    chk("idle_before", 32'({M_BUSY, M_DONE}), 32'd0);
    M_EXECUTE = 1'b1; M_RW = rw; M_ADDR = addr; M_DIN = din; B_ACK = 1'b0;
    cur_rw = rw; cur_hold = hold; busy_ok = 1; quiet_ok = 1;
    @(negedge CLK);
    for (int k = 0; k < 16; k++) begin
      a_obs[k] = B_BUS_OUT;
      mid_check(1'b1, 1'b0);
      junk();
      @(negedge CLK);
    end
    chk("addr_stream", 32'(a_obs), 32'(exp_q.pop_front()));
    ack_phase(da, alen);
    if (rw) begin
      for (int k = 0; k < 8; k++) begin
        if (k == abort_bit) begin
          void'(exp_q.pop_front());
          do_abort();
          return;
        end
        d_obs[k] = B_BUS_OUT;
        mid_check(1'b0, 1'b0);
        junk();
        @(negedge CLK);
      end
      chk("write_stream", 32'(d_obs), 32'(exp_q.pop_front()));
      ack_phase(dw, alen);
    end else begin
      for (int k = 0; k < 8; k++) begin
        mid_check(1'b0, 1'b1);
        junk();
        B_BUS_IN = rdata[k];
        @(negedge CLK);
      end
      last_rd = rdata;
    end
    chk("done_pulse", 32'(M_DONE), 32'd1);
    chk("dvalid_pulse", 32'(M_DVALID), 32'(!rw));
    chk("dout_value", 32'(M_DOUT), 32'(last_rd));
    chk("busy_in_done", 32'({M_BUSY, AD_SEL, B_BUS_OUT, M_ERR}), 32'b1000);
    junk();
    M_EXECUTE = hold;
    @(negedge CLK);
    chk("after_done", 32'({M_BUSY, M_DONE, M_DVALID, M_ERR, AD_SEL, B_BUS_OUT}), 32'd0);
    chk("busy_phase", 32'(busy_ok), 32'd1);
    chk("bus_quiet", 32'(quiet_ok), 32'd1);
  endtask

  // ---- stimulus ----
  initial begin
    RSTN = 1'b0; M_EXECUTE = 1'b0; M_RW = 1'b0; M_ADDR = '0; M_DIN = '0;
    B_BUS_IN = 1'b0; B_ACK = 1'b0; B_SBSY = 1'b0;
    last_rd = 8'h00; cur_rw = 1'b0; cur_hold = 0;
    repeat (3) @(negedge CLK);
    chk("reset_outs", 32'({AD_SEL, B_BUS_OUT, M_BUSY, M_DONE, M_DVALID, M_ERR, B_RW}), 32'd0);
    chk("reset_dout", 32'(M_DOUT), 32'd0);
    RSTN = 1'b1;
    @(negedge CLK);

    // Directed write and read with immediate single-cycle acks.
    xfer(1'b1, 16'hA5C3, 8'h96, 8'h00, 0, 0, 1, 0, -1);
    xfer(1'b0, 16'h0004, 8'h00, 8'h3C, 0, 0, 1, 0, -1);

    // Execute held through a whole transfer, then a back-to-back accept.
    xfer(1'b0, 16'h1234, 8'h00, 8'hA7, 0, 0, 1, 1, -1);
    xfer(1'b1, 16'h8001, 8'h5A, 8'h00, 1, 2, 2, 0, -1);

    // Randomized transfers.
    for (int i = 0; i < 12; i++) begin
      xfer(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), 8'($urandom),
           $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(1, 3), 0, -1);
    end

    // Make sure a nonzero read value is held before the reset abort.
    xfer(1'b0, 16'hFFFF, 8'h00, 8'hE1, 2, 0, 1, 0, -1);
    xfer(1'b1, 16'h00F0, 8'hFF, 8'h00, 0, 0, 1, 0, 3);

    // Address phase with no acknowledge.
    M_EXECUTE = 1'b1; M_RW = 1'b1; M_ADDR = 16'h5555; M_DIN = 8'h11; B_ACK = 1'b0;
    cur_hold = 0;
    @(negedge CLK);
    M_EXECUTE = 1'b0;
    repeat (16) @(negedge CLK);
`ifdef MASTER_PORT_ACK_TIMEOUT_EN
    quiet_ok = 1;
    for (int j = 0; j < 32; j++) begin
      if (M_ERR !== 1'b0 || M_BUSY !== 1'b1) quiet_ok = 0;
      junk();
      B_ACK = 1'b0;
      @(negedge CLK);
    end
    M_EXECUTE = 1'b0;
    chk("tmo_wait_quiet", 32'(quiet_ok), 32'd1);
    chk("tmo_err_pulse", 32'(M_ERR), 32'd1);
    chk("tmo_idle", 32'({M_BUSY, AD_SEL, M_DONE, M_DVALID}), 32'd0);
    chk("tmo_dout_kept", 32'(M_DOUT), 32'(last_rd));
    @(negedge CLK);
    chk("tmo_err_single", 32'(M_ERR), 32'd0);
`else
    quiet_ok = 1;
    for (int j = 0; j < 1000; j++) begin
      if (M_ERR !== 1'b0 || M_BUSY !== 1'b1 || AD_SEL !== 1'b0) quiet_ok = 0;
      junk();
      B_ACK = 1'b0;
      @(negedge CLK);
    end
    chk("no_tmo_still_waiting", 32'(quiet_ok), 32'd1);
    chk("no_tmo_busy", 32'(M_BUSY), 32'd1);
    RSTN = 1'b0;
    M_EXECUTE = 1'b0;
    last_rd = 8'h00;
    @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);
`endif

    // Normal operation afterwards.
    xfer(1'b0, 16'h7E81, 8'h00, 8'h5B, 1, 0, 1, 0, -1);
    xfer(1'b1, 16'h0102, 8'hC4, 8'h00, 0, 3, 1, 0, -1);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
